imem_fetch_responder: RTL

- Instruction-memory responder serving the fetch stage's requests over a req/ack handshake.
- Holds a word-addressed instruction ROM/RAM, preloaded through a separate write port.
- Inserts a configurable number of wait states, so the pipeline front end can be exercised against slow memory.

---
 rtl/imem_fetch_responder.sv | 179 +++++++++++++++++
 1 files changed

// File: rtl/imem_fetch_responder.sv
// Instruction memory that answers fetch req/ack with WAIT_STATES extra cycles of latency.
// Optional macro IMEM_PREFETCH_EN adds a one-entry next-word prefetch buffer.
module imem_fetch_responder #(
  parameter int LEN         = 32,
  parameter int DEPTH       = 256,
  parameter int ADDR_W      = 8,
  parameter int WAIT_STATES = 0
) (
  input  logic           clock,
  input  logic           reset,
  input  logic           fetch_req,
  input  logic [LEN-1:0] fetch_addr,
  output logic           fetch_ack,
  output logic [LEN-1:0] fetch_data,
  output logic           fetch_err,
  output logic           busy,
  input  logic           load_we,
  input  logic [LEN-1:0] load_addr,
  input  logic [LEN-1:0] load_data
);

  localparam logic [LEN-3:0]  WORD_LIMIT = (LEN-2)'(DEPTH);
  localparam logic [ADDR_W:0] IDX_LIMIT  = (ADDR_W+1)'(DEPTH);
  localparam logic [3:0]      WS_LOAD    = 4'(WAIT_STATES);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT,
    ST_RESP
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [3:0]        r_cnt;
  logic [3:0]        w_cnt_nxt;
  logic [ADDR_W-1:0] r_idx;
  logic              r_oor;
  logic [LEN-1:0]    r_mem [DEPTH];

  logic              w_capture;
  logic              w_resp_fire;
  logic              w_pf_hit;
  logic [LEN-1:0]    w_pf_data;
  logic              w_fetch_oor;
  logic [ADDR_W-1:0] w_fetch_idx;
  logic              w_load_ok;
  logic [ADDR_W-1:0] w_load_idx;
  logic [LEN-1:0]    w_resp_word;
  logic [1:0]        w_unused_lsbs;

  assign w_fetch_oor   = (fetch_addr[LEN-1:2] >= WORD_LIMIT);
  assign w_fetch_idx   = fetch_addr[ADDR_W+1:2];
  assign w_load_ok     = load_we && (load_addr[LEN-1:2] < WORD_LIMIT);
  assign w_load_idx    = load_addr[ADDR_W+1:2];
  assign w_unused_lsbs = fetch_addr[1:0] ^ load_addr[1:0];

  // Write-first: a load landing on the word being read this cycle is forwarded.
  assign w_resp_word = (w_load_ok && (w_load_idx == r_idx)) ? load_data : r_mem[r_idx];

  assign busy = (r_state != ST_IDLE);

  always_ff @(posedge clock) begin
    if (w_load_ok) begin
      r_mem[w_load_idx] <= load_data;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_capture   = 1'b0;
    w_resp_fire = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (fetch_req && !w_pf_hit) begin
          w_capture   = 1'b1;
          w_cnt_nxt   = WS_LOAD;
          w_state_nxt = (WS_LOAD != 4'd0) ? ST_WAIT : ST_RESP;
        end
      end
      ST_WAIT: begin
        if (!fetch_req) begin
          w_state_nxt = ST_IDLE;
          w_cnt_nxt   = 4'd0;
        end else if (r_cnt == 4'd1) begin
          w_state_nxt = ST_RESP;
          w_cnt_nxt   = 4'd0;
        end else begin
          w_cnt_nxt = r_cnt - 4'd1;
        end
      end
      ST_RESP: begin
        w_resp_fire = 1'b1;
        w_state_nxt = ST_IDLE;
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_cnt_nxt   = 4'd0;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state    <= ST_IDLE;
      r_cnt      <= 4'd0;
      fetch_ack  <= 1'b0;
      fetch_data <= '0;
      fetch_err  <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_cnt     <= w_cnt_nxt;
      fetch_ack <= w_resp_fire || w_pf_hit;
      if (w_resp_fire) begin
        fetch_data <= r_oor ? '0 : w_resp_word;
        fetch_err  <= r_oor;
      end else if (w_pf_hit) begin
        fetch_data <= w_pf_data;
        fetch_err  <= 1'b0;
      end
    end
  end

  // Request address is latched once in IDLE; the requester may change it after ack.
  always_ff @(posedge clock) begin
    if (w_capture) begin
      r_idx <= w_fetch_idx;
      r_oor <= w_fetch_oor;
    end
  end

`ifdef IMEM_PREFETCH_EN
  logic              r_pf_valid;
  logic [ADDR_W-1:0] r_pf_tag;
  logic [LEN-1:0]    r_pf_data;
  logic [ADDR_W-1:0] w_pf_base;
  logic [ADDR_W:0]   w_pf_next_full;
  logic [ADDR_W-1:0] w_pf_next_idx;
  logic              w_pf_next_ok;
  logic [LEN-1:0]    w_pf_next_word;
  logic              w_pf_fill;
  logic              w_pf_kill;

  // A load to the buffered word makes the copy stale; a same-cycle fetch then misses.
  assign w_pf_kill = w_load_ok && (w_load_idx == r_pf_tag);
  assign w_pf_hit  = (r_state == ST_IDLE) && fetch_req && r_pf_valid && !w_fetch_oor &&
                     (w_fetch_idx == r_pf_tag) && !w_pf_kill;

  assign w_pf_base      = w_pf_hit ? r_pf_tag : r_idx;
  assign w_pf_next_full = {1'b0, w_pf_base} + (ADDR_W+1)'(1);
  assign w_pf_next_ok   = (w_pf_next_full < IDX_LIMIT);
  assign w_pf_next_idx  = w_pf_next_full[ADDR_W-1:0];
  assign w_pf_next_word = (w_load_ok && (w_load_idx == w_pf_next_idx)) ? load_data
                                                                       : r_mem[w_pf_next_idx];
  assign w_pf_fill      = (w_resp_fire && !r_oor) || w_pf_hit;
  assign w_pf_data      = r_pf_data;

  always_ff @(posedge clock) begin
    if (reset) begin
      r_pf_valid <= 1'b0;
    end else if (w_pf_fill) begin
      r_pf_valid <= w_pf_next_ok;
    end else if (w_pf_kill) begin
      r_pf_valid <= 1'b0;
    end
  end

  always_ff @(posedge clock) begin
    if (w_pf_fill) begin
      r_pf_tag  <= w_pf_next_idx;
      r_pf_data <= w_pf_next_word;
    end
  end
`else
  assign w_pf_hit  = 1'b0;
  assign w_pf_data = '0;
`endif

endmodule
